// File: rtl/border_multi.sv
// border_multi: overlays up to BOX_NUM rectangle borders on a YCbCr pixel stream (BORDER_TRN_EN selects weighted blend).
// Latency: fixed 2 cycles for every strobe and pixel component.
// Backpressure: none; one pixel accepted and one produced every cycle.
module border_multi #(
    parameter int BOX_NUM   = 8,
    parameter int PX_WD     = 8,
    parameter int COR_WIDTH = 12,
    parameter int IMG_HSZ   = 1920,
    parameter int IMG_VSZ   = 1200
) (
    input  logic                           border_clk,
    input  logic                           border_rst_n,
    input  logic                           i_fstr,
    input  logic                           i_fend,
    input  logic                           i_vstr,
    input  logic                           i_vend,
    input  logic                           i_hstr,
    input  logic                           i_hend,
    input  logic                           i_dvld,
    input  logic [PX_WD-1:0]               i_data_y,
    input  logic [PX_WD-1:0]               i_data_cb,
    input  logic [PX_WD-1:0]               i_data_cr,
    input  logic [BOX_NUM-1:0]             r_border_en,
    input  logic [BOX_NUM*COR_WIDTH-1:0]   r_box_xs,
    input  logic [BOX_NUM*COR_WIDTH-1:0]   r_box_xe,
    input  logic [BOX_NUM*COR_WIDTH-1:0]   r_box_ys,
    input  logic [BOX_NUM*COR_WIDTH-1:0]   r_box_ye,
    input  logic [3:0]                     r_border_width,
    input  logic [PX_WD-1:0]               r_border_y,
    input  logic [PX_WD-1:0]               r_border_cb,
    input  logic [PX_WD-1:0]               r_border_cr,
    input  logic [3:0]                     r_trn_rate,
    output logic                           o_fstr,
    output logic                           o_fend,
    output logic                           o_vstr,
    output logic                           o_vend,
    output logic                           o_hstr,
    output logic                           o_hend,
    output logic                           o_dvld,
    output logic [PX_WD-1:0]               o_data_y,
    output logic [PX_WD-1:0]               o_data_cb,
    output logic [PX_WD-1:0]               o_data_cr
);

    localparam int                CW   = COR_WIDTH;
    localparam logic [CW-1:0]     CMAX = '1;
    localparam logic [CW:0]       HSZ  = (CW+1)'(IMG_HSZ);
    localparam logic [CW:0]       VSZ  = (CW+1)'(IMG_VSZ);

    logic [CW-1:0]           hcnt, vcnt;
    logic [CW-1:0]           x_cur, y_cur;
    logic [CW:0]             xp, yp, wx;

    logic [BOX_NUM-1:0]      sh_en;
    logic [BOX_NUM*CW-1:0]   sh_xs, sh_xe, sh_ys, sh_ye;
    logic [3:0]              sh_w;
    logic [PX_WD-1:0]        sh_y, sh_cb, sh_cr;

    logic [BOX_NUM-1:0]      box_hit;
    logic                    in_img;
    logic                    hit_now;

    logic [6:0]              s1_strb, s2_strb;
    logic [PX_WD-1:0]        s1_y, s1_cb, s1_cr;
    logic                    s1_hit;
    logic [PX_WD-1:0]        new_y, new_cb, new_cr;

    // A strobe in the same cycle as a pixel restarts the count for that pixel.
    assign x_cur = i_hstr ? '0 : hcnt;
    assign y_cur = i_vstr ? '0 : vcnt;
    assign xp    = {1'b0, x_cur};
    assign yp    = {1'b0, y_cur};
    assign wx    = {{(CW-3){1'b0}}, sh_w};

    always_ff @(posedge border_clk or negedge border_rst_n) begin
        if (!border_rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            if (i_dvld)
                hcnt <= (x_cur == CMAX) ? CMAX : x_cur + 1'b1;
            else if (i_hstr)
                hcnt <= '0;
            if (i_hend)
                vcnt <= (y_cur == CMAX) ? CMAX : y_cur + 1'b1;
            else if (i_vstr)
                vcnt <= '0;
        end
    end

    always_ff @(posedge border_clk or negedge border_rst_n) begin
        if (!border_rst_n) begin
            sh_en <= '0;
            sh_xs <= '0;
            sh_xe <= '0;
            sh_ys <= '0;
            sh_ye <= '0;
            sh_w  <= '0;
            sh_y  <= '0;
            sh_cb <= '0;
            sh_cr <= '0;
        end else if (i_fstr) begin
            sh_en <= r_border_en;
            sh_xs <= r_box_xs;
            sh_xe <= r_box_xe;
            sh_ys <= r_box_ys;
            sh_ye <= r_box_ye;
            sh_w  <= r_border_width;
            sh_y  <= r_border_y;
            sh_cb <= r_border_cb;
            sh_cr <= r_border_cr;
        end
    end

    // One extra bit keeps xs+w from wrapping and lets xe<w mark an empty interior.
    for (genvar k = 0; k < BOX_NUM; k++) begin : g_box
        logic [CW:0] xs, xe, ys, ye;
        logic        outer, in_x, in_y;
        assign xs    = {1'b0, sh_xs[k*CW +: CW]};
        assign xe    = {1'b0, sh_xe[k*CW +: CW]};
        assign ys    = {1'b0, sh_ys[k*CW +: CW]};
        assign ye    = {1'b0, sh_ye[k*CW +: CW]};
        assign outer = sh_en[k] && (xs <= xp) && (xp <= xe) && (ys <= yp) && (yp <= ye);
        assign in_x  = (xe >= wx) && (xs + wx <= xp) && (xp <= xe - wx);
        assign in_y  = (ye >= wx) && (ys + wx <= yp) && (yp <= ye - wx);
        assign box_hit[k] = outer && !(in_x && in_y);
    end

    assign in_img  = (xp < HSZ) && (yp < VSZ);
    assign hit_now = i_dvld && in_img && (|box_hit);

    always_ff @(posedge border_clk or negedge border_rst_n) begin
        if (!border_rst_n) begin
            s1_strb <= '0;
            s1_y    <= '0;
            s1_cb   <= '0;
            s1_cr   <= '0;
            s1_hit  <= 1'b0;
        end else begin
            s1_strb <= {i_fstr, i_fend, i_vstr, i_vend, i_hstr, i_hend, i_dvld};
            s1_y    <= i_data_y;
            s1_cb   <= i_data_cb;
            s1_cr   <= i_data_cr;
            s1_hit  <= hit_now;
        end
    end

`ifdef BORDER_TRN_EN
    localparam int AW = PX_WD + 4;

    logic [3:0] sh_t, t_sat;

    always_ff @(posedge border_clk or negedge border_rst_n) begin
        if (!border_rst_n)
            sh_t <= '0;
        else if (i_fstr)
            sh_t <= r_trn_rate;
    end

    assign t_sat = (sh_t > 4'd8) ? 4'd8 : sh_t;

    function automatic logic [PX_WD-1:0] blend(input logic [PX_WD-1:0] b,
                                               input logic [PX_WD-1:0] c,
                                               input logic [3:0]       t);
        logic [AW-1:0] sum;
        sum = AW'(b) * AW'(t) + AW'(c) * AW'(4'd8 - t) + AW'(4);
        return sum[PX_WD+2:3];
    endfunction

    assign new_y  = blend(sh_y,  s1_y,  t_sat);
    assign new_cb = blend(sh_cb, s1_cb, t_sat);
    assign new_cr = blend(sh_cr, s1_cr, t_sat);
`else
    logic unused_trn;
    assign unused_trn = ^r_trn_rate;

    assign new_y  = sh_y;
    assign new_cb = sh_cb;
    assign new_cr = sh_cr;
`endif

    always_ff @(posedge border_clk or negedge border_rst_n) begin
        if (!border_rst_n) begin
            s2_strb   <= '0;
            o_data_y  <= '0;
            o_data_cb <= '0;
            o_data_cr <= '0;
        end else begin
            s2_strb   <= s1_strb;
            o_data_y  <= s1_hit ? new_y  : s1_y;
            o_data_cb <= s1_hit ? new_cb : s1_cb;
            o_data_cr <= s1_hit ? new_cr : s1_cr;
        end
    end

    assign {o_fstr, o_fend, o_vstr, o_vend, o_hstr, o_hend, o_dvld} = s2_strb;

endmodule
